// File: rtl/ip_rx_mp.sv
// IPv4 receive header parser: captures and verifies the header, routes accepted frames to a protocol channel.
// Optional macro IP_RX_BCAST_EN: broadcast destination IP, or broadcast MAC with local IP, passes the address checks.
//
// state   | meaning
// IDLE    | waiting for ip_rx_req with a valid byte
// HDR     | capturing header fields, summing checksum words
// CHECK   | single cycle, verdict computed and registered
// PAYLOAD | accepted frame, counting bytes to the tracked length
// DROP    | rejected frame, counting bytes to the tracked length

module ip_rx_mp #(
  parameter int unsigned              NUM_PROTO  = 2,
  parameter logic [NUM_PROTO*8-1:0]   PROTO_LIST = {8'h01, 8'h11},
  parameter int unsigned              MIN_LEN    = 46
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          local_ip_addr,
  input  logic [47:0]          local_mac_addr,
  input  logic [47:0]          mac_rx_dest_mac_addr,
  input  logic [7:0]           ip_rx_data,
  input  logic                 ip_rx_valid,
  input  logic                 ip_rx_req,
  output logic [NUM_PROTO-1:0] proto_rx_req,
  output logic                 hdr_ok,
  output logic                 hdr_error,
  output logic [2:0]           hdr_error_code,
  output logic [15:0]          upper_layer_data_length,
  output logic [15:0]          ip_total_data_length,
  output logic [7:0]           net_protocol,
  output logic [31:0]          ip_rec_source_addr,
  output logic [31:0]          ip_rec_dest_addr,
  output logic                 ip_rx_end,
  output logic                 ip_rx_abort
);

  localparam logic [15:0] MIN_LEN16 = MIN_LEN[15:0];

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_CHECK   = 3'd2,
    S_PAYLOAD = 3'd3,
    S_DROP    = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [19:0] csum_q, csum_d;
  logic [7:0]  hi_q, hi_d;
  logic [3:0]  ver_q, ver_d;
  logic [3:0]  ihl_q, ihl_d;
  logic [15:0] tot_q, tot_d;
  logic        mf_q, mf_d;
  logic [12:0] off_q, off_d;
  logic [7:0]  proto_q, proto_d;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;

  logic [NUM_PROTO-1:0] req_q, req_d;
  logic        ok_q, ok_d;
  logic        err_q, err_d;
  logic [2:0]  code_q, code_d;
  logic [15:0] ulen_q, ulen_d;
  logic [15:0] tlen_q, tlen_d;
  logic [7:0]  nproto_q, nproto_d;
  logic [31:0] srco_q, srco_d;
  logic [31:0] dsto_q, dsto_d;
  logic        end_q, end_d;
  logic        abort_q, abort_d;

  logic        start;
  logic        cap;
  logic [15:0] byte_idx;
  logic [15:0] cnt_inc;
  logic [3:0]  ihl_eff;
  logic [15:0] hdr_len;
  logic [15:0] tot_eff;
  logic [19:0] fold1, fold2;
  logic        csum_ok;
  logic        mac_ok, ip_ok, bcast_pass;
  logic        proto_hit;
  logic [NUM_PROTO-1:0] proto_sel;
  logic [2:0]  vcode;
  logic        done;

  assign start    = ip_rx_valid & ip_rx_req;
  assign cap      = ip_rx_valid & (start | (state_q == S_HDR));
  assign byte_idx = start ? 16'd0 : cnt_q;
  assign cnt_inc  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  // A short IHL still walks a minimum 20-byte header before the verdict
  assign ihl_eff  = (ihl_q < 4'd5) ? 4'd5 : ihl_q;
  assign hdr_len  = {10'd0, ihl_eff, 2'b00};
  assign tot_eff  = (tot_q < MIN_LEN16) ? MIN_LEN16 : tot_q;

  assign fold1   = {4'd0, csum_q[15:0]} + {16'd0, csum_q[19:16]};
  assign fold2   = {4'd0, fold1[15:0]} + {16'd0, fold1[19:16]};
  assign csum_ok = (fold2 == 20'h0FFFF);

  assign mac_ok = (mac_rx_dest_mac_addr == local_mac_addr);
  assign ip_ok  = (dst_q == local_ip_addr);
`ifdef IP_RX_BCAST_EN
  assign bcast_pass = (dst_q == 32'hFFFF_FFFF) |
                      ((mac_rx_dest_mac_addr == 48'hFFFF_FFFF_FFFF) & ip_ok);
`else
  assign bcast_pass = 1'b0;
`endif

  always_comb begin
    proto_hit = 1'b0;
    proto_sel = '0;
    for (int i = 0; i < int'(NUM_PROTO); i++) begin
      if (!proto_hit && (proto_q == PROTO_LIST[8*i +: 8])) begin
        proto_sel[i] = 1'b1;
        proto_hit    = 1'b1;
      end
    end
  end

  always_comb begin
    vcode = 3'd0;
    if (ver_q != 4'd4)                              vcode = 3'd1;
    else if ((ihl_q < 4'd5) || (tot_q < hdr_len))   vcode = 3'd2;
    else if (!csum_ok)                              vcode = 3'd3;
    else if (!bcast_pass && !mac_ok)                vcode = 3'd4;
    else if (!bcast_pass && !ip_ok)                 vcode = 3'd5;
    else if (mf_q || (off_q != 13'd0))              vcode = 3'd6;
    else if (!proto_hit)                            vcode = 3'd7;
  end

  // Header field capture and checksum accumulation
  always_comb begin
    csum_d  = csum_q;
    hi_d    = hi_q;
    ver_d   = ver_q;
    ihl_d   = ihl_q;
    tot_d   = tot_q;
    mf_d    = mf_q;
    off_d   = off_q;
    proto_d = proto_q;
    src_d   = src_q;
    dst_d   = dst_q;
    if (start) csum_d = '0;
    if (cap) begin
      if (!byte_idx[0]) hi_d = ip_rx_data;
      else              csum_d = csum_q + {4'd0, hi_q, ip_rx_data};
      case (byte_idx)
        16'd0:  begin ver_d = ip_rx_data[7:4]; ihl_d = ip_rx_data[3:0]; end
        16'd2:  tot_d[15:8]  = ip_rx_data;
        16'd3:  tot_d[7:0]   = ip_rx_data;
        16'd6:  begin mf_d = ip_rx_data[5]; off_d[12:8] = ip_rx_data[4:0]; end
        16'd7:  off_d[7:0]   = ip_rx_data;
        16'd9:  proto_d      = ip_rx_data;
        16'd12: src_d[31:24] = ip_rx_data;
        16'd13: src_d[23:16] = ip_rx_data;
        16'd14: src_d[15:8]  = ip_rx_data;
        16'd15: src_d[7:0]   = ip_rx_data;
        16'd16: dst_d[31:24] = ip_rx_data;
        16'd17: dst_d[23:16] = ip_rx_data;
        16'd18: dst_d[15:8]  = ip_rx_data;
        16'd19: dst_d[7:0]   = ip_rx_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = '0;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    end_d    = 1'b0;
    abort_d  = 1'b0;
    code_d   = code_q;
    ulen_d   = ulen_q;
    tlen_d   = tlen_q;
    nproto_d = nproto_q;
    srco_d   = srco_q;
    dsto_d   = dsto_q;
    done     = 1'b0;
    if (start) begin
      // A new first byte always restarts parsing; mid-frame it abandons the old frame
      state_d = S_HDR;
      cnt_d   = 16'd1;
      abort_d = (state_q != S_IDLE);
    end else begin
      if (ip_rx_valid && (state_q != S_IDLE)) cnt_d = cnt_inc;
      case (state_q)
        S_HDR: begin
          if (ip_rx_valid && (cnt_q == hdr_len - 16'd1)) state_d = S_CHECK;
        end
        S_CHECK: begin
          code_d   = vcode;
          ulen_d   = tot_q - hdr_len;
          tlen_d   = tot_eff;
          nproto_d = proto_q;
          srco_d   = src_q;
          dsto_d   = dst_q;
          if (vcode == 3'd0) begin
            ok_d    = 1'b1;
            req_d   = proto_sel;
            state_d = S_PAYLOAD;
          end else begin
            err_d   = 1'b1;
            state_d = S_DROP;
          end
          done = (cnt_d >= tot_eff);
        end
        S_PAYLOAD, S_DROP: begin
          done = (cnt_d >= tlen_q) || (cnt_q == 16'hFFFF);
        end
        default: ;
      endcase
      if (done) begin
        end_d   = 1'b1;
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      csum_q   <= '0;
      hi_q     <= '0;
      ver_q    <= '0;
      ihl_q    <= '0;
      tot_q    <= '0;
      mf_q     <= 1'b0;
      off_q    <= '0;
      proto_q  <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      req_q    <= '0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= '0;
      ulen_q   <= '0;
      tlen_q   <= '0;
      nproto_q <= '0;
      srco_q   <= '0;
      dsto_q   <= '0;
      end_q    <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      csum_q   <= csum_d;
      hi_q     <= hi_d;
      ver_q    <= ver_d;
      ihl_q    <= ihl_d;
      tot_q    <= tot_d;
      mf_q     <= mf_d;
      off_q    <= off_d;
      proto_q  <= proto_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      req_q    <= req_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      code_q   <= code_d;
      ulen_q   <= ulen_d;
      tlen_q   <= tlen_d;
      nproto_q <= nproto_d;
      srco_q   <= srco_d;
      dsto_q   <= dsto_d;
      end_q    <= end_d;
      abort_q  <= abort_d;
    end
  end

  assign proto_rx_req            = req_q;
  assign hdr_ok                  = ok_q;
  assign hdr_error               = err_q;
  assign hdr_error_code          = code_q;
  assign upper_layer_data_length = ulen_q;
  assign ip_total_data_length    = tlen_q;
  assign net_protocol            = nproto_q;
  assign ip_rec_source_addr      = srco_q;
  assign ip_rec_dest_addr        = dsto_q;
  assign ip_rx_end               = end_q;
  assign ip_rx_abort             = abort_q;

endmodule
